// File: rtl/inst_mem_ctrl.sv
// Instruction-memory sequencer: turns loader bytes into single-cycle write strobes and
// serves aligned word fetches once a program is loaded. The loader always wins arbitration.
module inst_mem_ctrl #(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WORD_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_prog_start,
  input  logic [ADDR_W-1:0] i_prog_base,
  input  logic              i_prog_valid,
  input  logic [7:0]        i_prog_byte,
  input  logic              i_prog_done,
  output logic              o_prog_ready,
  output logic              o_prog_err,
  output logic [ADDR_W-1:0] o_byte_count,
  output logic              o_loaded,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_valid,
  output logic [WORD_W-1:0] o_fetch_data,
  output logic              o_fetch_err,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [7:0]        o_mem_data,
  output logic              o_mem_cs,
  input  logic [WORD_W-1:0] i_mem_data,
  output logic              o_busy
);

  typedef enum logic [2:0] {StIdle, StLoad, StWrite, StHold, StFetch} state_e;

  localparam logic [ADDR_W:0] DepthExt = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic                err_q, err_d;
  logic                loaded_q, loaded_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                cs_q, cs_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                fvalid_q, fvalid_d;
  logic                ferr_q, ferr_d;
  logic [WORD_W-1:0]   fdata_q, fdata_d;

  logic                ptr_in_range;
  logic [ADDR_W:0]     fetch_end;
  logic                fetch_ok;

  // Range checks are done one bit wider so addresses near the top cannot wrap.
  assign ptr_in_range = {1'b0, ptr_q} < DepthExt;
  assign fetch_end    = {1'b0, i_fetch_addr} + (ADDR_W+1)'(3);
  assign fetch_ok     = loaded_q && (i_fetch_addr[1:0] == 2'b00) && (fetch_end < DepthExt);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      loaded_q <= 1'b0;
      pend_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cs_q     <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      fvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      fdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      loaded_q <= loaded_d;
      pend_q   <= pend_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cs_q     <= cs_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      fvalid_q <= fvalid_d;
      ferr_q   <= ferr_d;
      fdata_q  <= fdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_prog_start)                state_d = StLoad;
        else if (i_fetch_req && fetch_ok) state_d = StFetch;
      end
      StLoad: begin
        if (i_prog_start)      state_d = StLoad;
        else if (i_prog_valid) begin
          if (ptr_in_range)     state_d = StWrite;
          else if (i_prog_done) state_d = StIdle;
        end else if (i_prog_done) begin
          state_d = StIdle;
        end
      end
      StWrite: state_d = StHold;
      StHold:  state_d = pend_q ? StIdle : StLoad;
      StFetch: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d    = ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    loaded_d = loaded_q;
    pend_d   = pend_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    fvalid_d = 1'b0;
    ferr_d   = 1'b0;
    fdata_d  = fdata_q;
    unique case (state_q)
      StIdle, StLoad: begin
        if (i_prog_start) begin
          ptr_d    = i_prog_base;
          addr_d   = i_prog_base;
          count_d  = '0;
          err_d    = 1'b0;
          loaded_d = 1'b0;
          pend_d   = 1'b0;
        end else if (state_q == StIdle) begin
          if (i_fetch_req) begin
            if (fetch_ok) begin
              addr_d = i_fetch_addr;
            end else begin
              fvalid_d = 1'b1;
              ferr_d   = 1'b1;
              fdata_d  = '0;
            end
          end
        end else if (i_prog_valid) begin
          if (ptr_in_range) begin
            wdata_d = i_prog_byte;
            pend_d  = i_prog_done;
          end else begin
            // A dropped byte still honours a coincident done.
            err_d    = 1'b1;
            loaded_d = loaded_q | i_prog_done;
          end
        end else if (i_prog_done) begin
          loaded_d = 1'b1;
        end
      end
      StWrite: ;
      StHold: begin
        ptr_d  = ptr_q + 1'b1;
        addr_d = ptr_q + 1'b1;
        if ({1'b0, count_q} < DepthExt) count_d = count_q + 1'b1;
        if (pend_q) begin
          loaded_d = 1'b1;
          pend_d   = 1'b0;
        end
      end
      StFetch: begin
        fdata_d  = i_mem_data;
        fvalid_d = 1'b1;
      end
      default: ;
    endcase
    // Strobe/status flags follow the state being entered so they are registered outputs.
    cs_d    = (state_d == StWrite);
    ready_d = (state_d == StLoad);
    busy_d  = (state_d != StIdle);
  end

  assign o_prog_ready  = ready_q;
  assign o_prog_err    = err_q;
  assign o_byte_count  = count_q;
  assign o_loaded      = loaded_q;
  assign o_fetch_valid = fvalid_q;
  assign o_fetch_data  = fdata_q;
  assign o_fetch_err   = ferr_q;
  assign o_mem_address = addr_q;
  assign o_mem_data    = wdata_q;
  assign o_mem_cs      = cs_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Bench for inst_mem_ctrl: memory model, transaction-level scoreboard for writes and
// fetches, and directed scenarios with literal expectations.
module tb_inst_mem_ctrl;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 8;
  localparam int WORD_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_prog_start = 1'b0;
  logic [7:0]        i_prog_base = '0;
  logic              i_prog_valid = 1'b0;
  logic [7:0]        i_prog_byte = '0;
  logic              i_prog_done = 1'b0;
  logic              o_prog_ready, o_prog_err, o_loaded;
  logic [7:0]        o_byte_count;
  logic              i_fetch_req = 1'b0;
  logic [7:0]        i_fetch_addr = '0;
  logic              o_fetch_valid, o_fetch_err;
  logic [31:0]       o_fetch_data;
  logic [7:0]        o_mem_address, o_mem_data;
  logic              o_mem_cs;
  logic [31:0]       mem_rd;
  logic              o_busy;

  always #5 clk = ~clk;

  inst_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_prog_start(i_prog_start), .i_prog_base(i_prog_base), .i_prog_valid(i_prog_valid),
    .i_prog_byte(i_prog_byte), .i_prog_done(i_prog_done), .o_prog_ready(o_prog_ready),
    .o_prog_err(o_prog_err), .o_byte_count(o_byte_count), .o_loaded(o_loaded),
    .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr), .o_fetch_valid(o_fetch_valid),
    .o_fetch_data(o_fetch_data), .o_fetch_err(o_fetch_err), .o_mem_address(o_mem_address),
    .o_mem_data(o_mem_data), .o_mem_cs(o_mem_cs), .i_mem_data(mem_rd), .o_busy(o_busy)
  );

  // Byte memory with level write (sampled on the clock) and asynchronous word read.
  logic [7:0] mem [DEPTH];
  always @(posedge clk)
    if (o_mem_cs && int'(o_mem_address) < DEPTH) mem[o_mem_address[6:0]] <= o_mem_data;

  always_comb begin
    int a;
    mem_rd = '0;
    for (int b = 0; b < 4; b++) begin
      a = int'(o_mem_address) + b;
      if (a < DEPTH) mem_rd[8*b +: 8] = mem[7'(a)];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  int         mptr, mcount;
  bit         merr, mloaded;
  logic [7:0] shadow [DEPTH];

  typedef struct {int cyc; logic [7:0] addr; logic [7:0] data;} wr_t;
  typedef struct {int cyc; logic err; logic [31:0] data;} fr_t;
  wr_t wq[$];
  fr_t fq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int a);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = shadow[a + j];
    return w;
  endfunction

  // Compare process: every write strobe and fetch response against the scoreboard.
  wr_t        we_e;
  fr_t        fe_e;
  logic       prev_cs = 1'b0;
  logic [7:0] prev_addr, prev_data;
  always @(negedge clk) begin
    if (rst) begin
      prev_cs = 1'b0;
    end else begin
      if (o_mem_cs) begin
        check("strobe exclusive", {29'd0, o_prog_ready, o_fetch_valid, o_busy}, 32'd1);
        if (wq.size() == 0) begin
          check("unexpected write", 32'd1, 32'd0);
        end else begin
          we_e = wq.pop_front();
          check("write cycle", 32'(cyc), 32'(we_e.cyc));
          check("write addr", {24'd0, o_mem_address}, {24'd0, we_e.addr});
          check("write data", {24'd0, o_mem_data}, {24'd0, we_e.data});
        end
      end
      if (prev_cs) begin
        check("strobe width", {31'd0, o_mem_cs}, 32'd0);
        check("addr hold", {24'd0, o_mem_address}, {24'd0, prev_addr});
        check("data hold", {24'd0, o_mem_data}, {24'd0, prev_data});
      end
      if (wq.size() > 0 && wq[0].cyc < cyc) begin
        check("missed write", 32'd0, 32'd1);
        void'(wq.pop_front());
      end
      if (o_fetch_valid) begin
        if (fq.size() == 0) begin
          check("unexpected fetch", 32'd1, 32'd0);
        end else begin
          fe_e = fq.pop_front();
          check("fetch cycle", 32'(cyc), 32'(fe_e.cyc));
          check("fetch err", {31'd0, o_fetch_err}, {31'd0, fe_e.err});
          check("fetch data", o_fetch_data, fe_e.data);
        end
      end
      if (fq.size() > 0 && fq[0].cyc < cyc) begin
        check("missed fetch", 32'd0, 32'd1);
        void'(fq.pop_front());
      end
      prev_cs   = o_mem_cs;
      prev_addr = o_mem_address;
      prev_data = o_mem_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_start(input logic [7:0] base);
    i_prog_start = 1'b1;
    i_prog_base  = base;
    tick();
    i_prog_start = 1'b0;
    mptr = int'(base); mcount = 0; merr = 1'b0; mloaded = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit done, input bit model_it,
                           output int acc_edge);
    bit seen;
    bit ok = 1'b0;
    i_prog_valid = 1'b1; i_prog_byte = b; i_prog_done = done;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      seen = o_prog_ready;
      tick();
      if (seen) ok = 1'b1;
    end
    i_prog_valid = 1'b0; i_prog_done = 1'b0;
    acc_edge = cyc;
    check("byte accepted", {31'd0, ok}, 32'd1);
    if (ok && model_it) begin
      if (mptr < DEPTH) begin
        wq.push_back('{cyc: cyc, addr: 8'(mptr), data: b});
        shadow[mptr] = b;
        mptr++;
        if (mcount < DEPTH) mcount++;
      end else begin
        merr = 1'b1;
      end
      if (done) mloaded = 1'b1;
    end
  endtask

  task automatic prog_done(output int d_edge);
    bit seen;
    bit ok = 1'b0;
    i_prog_done = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      seen = o_prog_ready;
      tick();
      if (seen) ok = 1'b1;
    end
    i_prog_done = 1'b0;
    d_edge = cyc;
    check("done accepted", {31'd0, ok}, 32'd1);
    mloaded = 1'b1;
  endtask

  task automatic wait_resp(output logic [31:0] got);
    bit seen = 1'b0;
    got = 'x;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (o_fetch_valid) begin
        seen = 1'b1;
        got = o_fetch_data;
        i_fetch_req = 1'b0;
      end
    end
    i_fetch_req = 1'b0;
    check("fetch response seen", {31'd0, seen}, 32'd1);
    tick();
  endtask

  task automatic fetch(input logic [7:0] a, output logic [31:0] got);
    bit ok;
    ok = mloaded && (a[1:0] == 2'b00) && (int'(a) + 3 < DEPTH);
    if (ok) fq.push_back('{cyc: cyc + 2, err: 1'b0, data: word_of(int'(a))});
    else    fq.push_back('{cyc: cyc + 1, err: 1'b1, data: 32'd0});
    i_fetch_req = 1'b1; i_fetch_addr = a;
    wait_resp(got);
  endtask

  task automatic check_status(input string name);
    check({name, " count"}, {24'd0, o_byte_count}, 32'(mcount));
    check({name, " err"}, {31'd0, o_prog_err}, {31'd0, merr});
    check({name, " loaded"}, {31'd0, o_loaded}, {31'd0, mloaded});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int          e [4];
    int          d;
    logic [31:0] got;
    logic [7:0]  bytes [4];

    foreach (mem[i]) mem[i] = 8'h00;
    foreach (shadow[i]) shadow[i] = 8'h00;
    mptr = 0; mcount = 0; merr = 1'b0; mloaded = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", {31'd0, o_busy}, 32'd0);
    check("rst ready", {31'd0, o_prog_ready}, 32'd0);
    check("rst cs", {31'd0, o_mem_cs}, 32'd0);
    check("rst loaded", {31'd0, o_loaded}, 32'd0);
    check("rst prog_err", {31'd0, o_prog_err}, 32'd0);
    check("rst count", {24'd0, o_byte_count}, 32'd0);
    check("rst fetch_valid", {31'd0, o_fetch_valid}, 32'd0);
    check("rst fetch_data", o_fetch_data, 32'd0);
    check("rst mem_address", {24'd0, o_mem_address}, 32'd0);
    tick();

    // Fetch before any load is rejected.
    fetch(8'h00, got);
    check("unloaded fetch data", got, 32'd0);

    // First program: one instruction at base 0.
    bytes = '{8'h13, 8'h00, 8'h00, 8'h00};
    prog_start(8'h00);
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 1'b0, 1'b1, e[i]);
    for (int i = 1; i < 4; i++) check("byte spacing", 32'(e[i] - e[i-1]), 32'd3);
    prog_done(d);
    tick();
    check_status("load0");
    check("load0 count lit", {24'd0, o_byte_count}, 32'd4);
    check("load0 loaded lit", {31'd0, o_loaded}, 32'd1);
    fetch(8'h00, got);
    check("fetch0 lit", got, 32'h0000_0013);
    fetch(8'h05, got);
    fetch(8'h7D, got);

    // Load near the top: two bytes land, two are dropped.
    bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    prog_start(8'h7E);
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 1'b0, 1'b1, e[i]);
    prog_done(d);
    tick();
    check_status("top");
    check("top err lit", {31'd0, o_prog_err}, 32'd1);
    check("top count lit", {24'd0, o_byte_count}, 32'd2);
    fetch(8'h7C, got);
    check("fetch 7C lit", got, 32'hBBAA_0000);
    fetch(8'h80, got);

    // Start and fetch in the same IDLE cycle: the load wins, fetch waits for done.
    i_fetch_req = 1'b1; i_fetch_addr = 8'h04;
    prog_start(8'h04);
    check("start wins busy", {31'd0, o_busy}, 32'd1);
    check("start wins ready", {31'd0, o_prog_ready}, 32'd1);
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 1'b0, 1'b1, e[i]);
    prog_done(d);
    fq.push_back('{cyc: d + 2, err: 1'b0, data: word_of(4)});
    wait_resp(got);
    check("held fetch lit", got, 32'h4433_2211);

    // Byte and done together: written, then loaded on leaving HOLD.
    prog_start(8'h08);
    send_byte(8'h5A, 1'b1, 1'b1, e[0]);
    tick();
    check("vd hold loaded", {31'd0, o_loaded}, 32'd0);
    check("vd hold busy", {31'd0, o_busy}, 32'd1);
    tick();
    check("vd idle loaded", {31'd0, o_loaded}, 32'd1);
    check("vd idle busy", {31'd0, o_busy}, 32'd0);
    check_status("vd");
    fetch(8'h08, got);
    check("vd fetch lit", got, 32'h0000_005A);

    // Reset asserted while the strobe is high.
    prog_start(8'h10);
    send_byte(8'h77, 1'b0, 1'b0, e[0]);
    check("in write cs", {31'd0, o_mem_cs}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async rst cs", {31'd0, o_mem_cs}, 32'd0);
    check("async rst loaded", {31'd0, o_loaded}, 32'd0);
    check("async rst ready", {31'd0, o_prog_ready}, 32'd0);
    check("async rst busy", {31'd0, o_busy}, 32'd0);
    mptr = 0; mcount = 0; merr = 1'b0; mloaded = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post rst busy", {31'd0, o_busy}, 32'd0);
    check("post rst ready", {31'd0, o_prog_ready}, 32'd0);
    fetch(8'h00, got);
    check("post rst fetch lit", got, 32'd0);

    repeat (4) tick();
    check("writes drained", 32'(wq.size()), 32'd0);
    check("fetches drained", 32'(fq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
